ram_burst_ctrl: RTL



---
 rtl/ram_ctrl_pkg.sv | 22 ++
 rtl/ram_rd_pipe.sv | 43 ++++
 rtl/ram_burst_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared constants for the RAM burst controller: bus widths, read-latency range and FSM encoding.
package ram_ctrl_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 5;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_CLEAR = 3'd4;

  function automatic int clamp_rd_lat(input int lat);
    if (lat < RD_LAT_MIN) return RD_LAT_MIN;
    if (lat > RD_LAT_MAX) return RD_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-return pipeline: tracks in-flight RAM reads and registers the returning data as a pulse stream.
module ram_rd_pipe
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_issue,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_empty
);

  logic [RD_LAT-1:0] r_vld;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        r_vld[i] <= r_vld[i-1];
      end
      r_vld[0]   <= i_issue;
      r_rd_valid <= r_vld[RD_LAT-1];
      // RAM output is only meaningful on the cycle the matching valid bit emerges
      if (r_vld[RD_LAT-1]) begin
        r_rd_data <= i_mem_data;
      end
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_empty    = ~|r_vld;

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst initiator for a single-port synchronous RAM with wrapping auto-increment addressing.
// Define RAM_BURST_CTRL_CLEAR_EN to add i_clear_req and a whole-RAM zero-fill state.
module ram_burst_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [ADDR_W-1:0] i_cmd_len,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_data_in,
  output logic              o_mem_wrenable,
  output logic              o_mem_rdenable,
`ifdef RAM_BURST_CTRL_CLEAR_EN
  input  logic              i_clear_req,
`endif
  input  logic [DATA_W-1:0] i_mem_data_out
);

  localparam int LAT = clamp_rd_lat(RD_LAT);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_remain;
  logic [ADDR_W-1:0] r_addr_hold;

  logic w_wr_fire;
  logic w_rd_issue;
  logic w_clr;
  logic w_step;
  logic w_last;
  logic w_on_bus;
  logic w_empty;

  assign w_wr_fire  = (r_state == ST_WRITE) && i_wr_valid;
  assign w_rd_issue = (r_state == ST_READ);
`ifdef RAM_BURST_CTRL_CLEAR_EN
  assign w_clr      = (r_state == ST_CLEAR);
`else
  assign w_clr      = 1'b0;
`endif
  assign w_step     = w_wr_fire | w_rd_issue | w_clr;
  assign w_last     = (r_remain == '0);
  assign w_on_bus   = (r_state == ST_WRITE) || (r_state == ST_READ) || w_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remain    <= '0;
      r_addr_hold <= '0;
    end else begin
      // Remember the last driven address so the bus stays put while idle or draining
      if (w_on_bus) begin
        r_addr_hold <= r_addr;
      end
      if (w_step) begin
        r_addr   <= r_addr + ADDR_W'(1);
        r_remain <= r_remain - ADDR_W'(1);
      end
      case (r_state)
        ST_IDLE: begin
`ifdef RAM_BURST_CTRL_CLEAR_EN
          if (i_clear_req) begin
            r_addr   <= '0;
            r_remain <= '1;
            r_state  <= ST_CLEAR;
          end else
`endif
          if (i_cmd_valid) begin
            r_addr   <= i_cmd_addr;
            r_remain <= i_cmd_len;
            r_state  <= i_cmd_write ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: if (w_wr_fire && w_last) r_state <= ST_IDLE;
        ST_READ:  if (w_last) r_state <= ST_DRAIN;
        ST_DRAIN: if (w_empty) r_state <= ST_IDLE;
`ifdef RAM_BURST_CTRL_CLEAR_EN
        ST_CLEAR: if (w_last) r_state <= ST_IDLE;
`endif
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  ram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (LAT)
  ) u_rd_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_issue    (w_rd_issue),
    .i_mem_data (i_mem_data_out),
    .o_rd_valid (o_rd_valid),
    .o_rd_data  (o_rd_data),
    .o_empty    (w_empty)
  );

  assign o_cmd_ready    = (r_state == ST_IDLE);
  assign o_wr_ready     = (r_state == ST_WRITE);
  assign o_busy         = (r_state != ST_IDLE) || !w_empty;
  assign o_mem_wrenable = w_wr_fire | w_clr;
  assign o_mem_rdenable = w_rd_issue;
  assign o_mem_address  = w_on_bus ? r_addr : r_addr_hold;
  assign o_mem_data_in  = (r_state == ST_WRITE) ? i_wr_data : '0;

endmodule
